// File: rtl/tsc_pkg.sv
// Shared types for the trigger-surround cache: FSM state encodings and window depth.
package tsc_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_FILL  = 4'd1,
    ST_ARMED = 4'd2,
    ST_POST  = 4'd3,
    ST_DONE  = 4'd4,
    ST_SEND  = 4'd5
  } tsc_state_e;

  // Window depth: pre-trigger samples, the trigger sample itself, post-trigger samples.
  function automatic int tsc_depth(input int pre, input int post);
    return pre + post + 1;
  endfunction

endpackage

// File: rtl/tsc_ring_buffer.sv
// DEPTH x DATA_W single-clock sample store: synchronous write port, registered read port.
// Read data holds until the next rd_en, so it can drive the readout bus directly.
module tsc_ring_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 33,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  // Array contents are never reset; only the read register is.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem[rd_addr];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rd_data_q <= '0;
    else        rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/trig_surround_cache.sv
// Trigger-surround capture cache: PRE samples before a threshold crossing, the trigger, POST after,
// streamed out one sample per req rising edge. TSC_AUTO_REARM_EN: re-enter FILL after readout.
module trig_surround_cache
  import tsc_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int PRE    = 16,
  parameter int POST   = 16,
  parameter int TIME_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  input  logic [DATA_W-1:0] threshold,
  input  logic              trig_fall,
  input  logic              sbf,
  input  logic              req,
  output logic              trd,
  output logic              cd,
  output logic              rdy,
  output logic [DATA_W-1:0] dat,
  output logic [TIME_W-1:0] trigtm,
  output logic              sd,
  output logic [3:0]        current_state
);

  localparam int DEPTH = tsc_depth(PRE, POST);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  tsc_state_e        state_q, state_d;
  logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d, trig_ptr_q, trig_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic [TIME_W-1:0] ts_q, ts_d, trigtm_q, trigtm_d;
  logic              trd_q, trd_d, cd_q, cd_d, rdy_q, rdy_d, sd_q, sd_d, req_q, req_d;
  logic              wr_en, rd_en, hit;
  logic [PTR_W-1:0]  rd_start;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Equality counts only on the current sample, never on the previous one.
  assign hit = trig_fall ? (prev_q > threshold && adc_data <= threshold)
                         : (prev_q < threshold && adc_data >= threshold);
  assign rd_start = PTR_W'((int'(trig_ptr_q) + DEPTH - PRE) % DEPTH);

  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    trig_ptr_d = trig_ptr_q;
    cnt_d      = cnt_q;
    prev_d     = prev_q;
    ts_d       = ts_q + 1'b1;
    trigtm_d   = trigtm_q;
    trd_d      = trd_q;
    cd_d       = cd_q;
    rdy_d      = 1'b0;
    sd_d       = 1'b0;
    req_d      = req;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_FILL;
        cnt_d   = '0;
        wptr_d  = '0;
      end
      ST_FILL: if (adc_valid) begin
        wr_en  = 1'b1;
        wptr_d = ptr_inc(wptr_q);
        prev_d = adc_data;
        if (cnt_q == CNT_W'(PRE - 1)) begin
          state_d = ST_ARMED;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 1'b1;
      end
      ST_ARMED: if (adc_valid) begin
        wr_en  = 1'b1;
        wptr_d = ptr_inc(wptr_q);
        prev_d = adc_data;
        if (hit) begin
          state_d    = ST_POST;
          trig_ptr_d = wptr_q;
          trigtm_d   = ts_q;
          trd_d      = 1'b1;
          cnt_d      = '0;
        end
      end
      ST_POST: if (adc_valid) begin
        wr_en  = 1'b1;
        wptr_d = ptr_inc(wptr_q);
        prev_d = adc_data;
        if (cnt_q == CNT_W'(POST - 1)) begin
          state_d = ST_DONE;
          cd_d    = 1'b1;
        end else cnt_d = cnt_q + 1'b1;
      end
      ST_DONE: if (sbf) begin
        state_d = ST_SEND;
        rptr_d  = rd_start;
        cnt_d   = '0;
      end
      ST_SEND: begin
        // sd_q high means the final sample is already out; leave one cycle after it.
        if (sd_q) begin
          trd_d = 1'b0;
          cd_d  = 1'b0;
`ifdef TSC_AUTO_REARM_EN
          state_d = ST_FILL;
          cnt_d   = '0;
          wptr_d  = '0;
`else
          state_d = ST_IDLE;
`endif
        end else if (req && !req_q) begin
          rd_en  = 1'b1;
          rptr_d = ptr_inc(rptr_q);
          cnt_d  = cnt_q + 1'b1;
          rdy_d  = 1'b1;
          sd_d   = (cnt_q == CNT_W'(DEPTH - 1));
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      wptr_q     <= '0;
      rptr_q     <= '0;
      trig_ptr_q <= '0;
      cnt_q      <= '0;
      prev_q     <= '0;
      ts_q       <= '0;
      trigtm_q   <= '0;
      trd_q      <= 1'b0;
      cd_q       <= 1'b0;
      rdy_q      <= 1'b0;
      sd_q       <= 1'b0;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      trig_ptr_q <= trig_ptr_d;
      cnt_q      <= cnt_d;
      prev_q     <= prev_d;
      ts_q       <= ts_d;
      trigtm_q   <= trigtm_d;
      trd_q      <= trd_d;
      cd_q       <= cd_d;
      rdy_q      <= rdy_d;
      sd_q       <= sd_d;
      req_q      <= req_d;
    end
  end

  tsc_ring_buffer #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (wr_en),
    .wr_addr(wptr_q),
    .wr_data(adc_data),
    .rd_en  (rd_en),
    .rd_addr(rptr_q),
    .rd_data(dat)
  );

  assign trd           = trd_q;
  assign cd            = cd_q;
  assign rdy           = rdy_q;
  assign sd            = sd_q;
  assign trigtm        = trigtm_q;
  assign current_state = state_q;

endmodule

// File: tb/tb_trig_surround_cache.sv
// Directed bench for trig_surround_cache with PRE=4, POST=4: table-driven capture rows plus
// hand-written readout, reset and ignored-input sequences.
module tb_trig_surround_cache;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0, adc_valid = 1'b0, trig_fall = 1'b0, sbf = 1'b0, req = 1'b0;
  logic [7:0]  adc_data = '0, threshold = '0;
  logic        trd, cd, rdy, sd;
  logic [7:0]  dat;
  logic [31:0] trigtm;
  logic [3:0]  current_state;

  int          total = 0;
  int          bad = 0;
  logic [31:0] cyc;
  logic [31:0] exp_tm = '0;
  logic [31:0] old_tm = '0;

  typedef struct {
    logic       rst;
    logic       start;
    logic       vld;
    logic [7:0] d;
    logic [7:0] thr;
    logic       fall;
    logic [3:0] st;
    logic       trd;
    logic       cd;
    logic       tm;
  } vec_t;

  vec_t vt[$];
  logic [7:0] exp_a [9];
  logic [7:0] exp_e [9];

`ifdef TSC_AUTO_REARM_EN
  localparam logic [3:0] ST_AFTER_SEND = 4'd1;
`else
  localparam logic [3:0] ST_AFTER_SEND = 4'd0;
`endif

  trig_surround_cache #(
    .DATA_W(8), .PRE(4), .POST(4), .TIME_W(32)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .adc_data(adc_data), .adc_valid(adc_valid),
    .threshold(threshold), .trig_fall(trig_fall), .sbf(sbf), .req(req),
    .trd(trd), .cd(cd), .rdy(rdy), .dat(dat), .trigtm(trigtm), .sd(sd),
    .current_state(current_state)
  );

  always #5 clk = ~clk;

  // Reference timestamp: cycles since reset release.
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= '0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic add(input int rst, input int st_in, input int vld, input int d, input int thr,
                     input int fall, input int st, input int t, input int c, input int tm);
    vec_t r;
    r.rst = rst[0]; r.start = st_in[0]; r.vld = vld[0]; r.d = d[7:0]; r.thr = thr[7:0];
    r.fall = fall[0]; r.st = st[3:0]; r.trd = t[0]; r.cd = c[0]; r.tm = tm[0];
    vt.push_back(r);
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      if (vt[i].rst) begin
        reset = 1'b0; start = 1'b0; adc_valid = 1'b0; sbf = 1'b0; req = 1'b0;
        @(posedge clk); #1;
        chk($sformatf("row%0d_rst_trd", i), 32'(trd), 0);
        chk($sformatf("row%0d_rst_cd", i), 32'(cd), 0);
        chk($sformatf("row%0d_rst_rdy", i), 32'(rdy), 0);
        chk($sformatf("row%0d_rst_sd", i), 32'(sd), 0);
        chk($sformatf("row%0d_rst_dat", i), 32'(dat), 0);
        chk($sformatf("row%0d_rst_trigtm", i), trigtm, 0);
        chk($sformatf("row%0d_rst_state", i), 32'(current_state), 32'(vt[i].st));
        reset = 1'b1;
      end else begin
        start = vt[i].start; adc_valid = vt[i].vld; adc_data = vt[i].d;
        threshold = vt[i].thr; trig_fall = vt[i].fall;
        if (vt[i].tm) exp_tm = cyc;
        @(posedge clk); #1;
        start = 1'b0; adc_valid = 1'b0;
        chk($sformatf("row%0d_state", i), 32'(current_state), 32'(vt[i].st));
        chk($sformatf("row%0d_trd", i), 32'(trd), 32'(vt[i].trd));
        chk($sformatf("row%0d_cd", i), 32'(cd), 32'(vt[i].cd));
        if (vt[i].tm) chk($sformatf("row%0d_trigtm", i), trigtm, exp_tm);
      end
    end
  endtask

  task automatic readout(input string nm, input logic [7:0] e [9], input int hold);
    int nrdy;
    sbf = 1'b1;
    @(posedge clk); #1;
    sbf = 1'b0;
    chk({nm, "_send_state"}, 32'(current_state), 5);
    for (int i = 0; i < 9; i++) begin
      int nh;
      nh = (i == 0 && hold != 0) ? 5 : 1;
      nrdy = 0;
      req = 1'b1;
      for (int c = 0; c < nh; c++) begin
        @(posedge clk); #1;
        if (rdy) nrdy++;
        if (c == 0) begin
          chk($sformatf("%s_rdy%0d", nm, i), 32'(rdy), 1);
          chk($sformatf("%s_dat%0d", nm, i), 32'(dat), 32'(e[i]));
          chk($sformatf("%s_sd%0d", nm, i), 32'(sd), (i == 8) ? 1 : 0);
        end
      end
      req = 1'b0;
      @(posedge clk); #1;
      if (rdy) nrdy++;
      chk($sformatf("%s_rdy_low%0d", nm, i), 32'(rdy), 0);
      chk($sformatf("%s_dat_hold%0d", nm, i), 32'(dat), 32'(e[i]));
      if (hold != 0 && i == 0) chk({nm, "_held_req_rdy_count"}, 32'(nrdy), 1);
      if (i == 8) begin
        chk({nm, "_state_after_sd"}, 32'(current_state), 32'(ST_AFTER_SEND));
        chk({nm, "_trd_after_sd"}, 32'(trd), 0);
        chk({nm, "_cd_after_sd"}, 32'(cd), 0);
      end
    end
  endtask

  initial begin
    int a_end, b_end, e_end, r_end;
    exp_a = '{60, 70, 80, 90, 110, 120, 130, 140, 150};
    exp_e = '{22, 33, 44, 55, 150, 160, 170, 180, 190};

    // A: rising, thr 100, trigger on 110.
    add(1,0,0,0,100,0, 0,0,0,0);
    add(0,1,0,0,100,0, 1,0,0,0);
    add(0,0,1,50,100,0, 1,0,0,0);
    add(0,0,1,60,100,0, 1,0,0,0);
    add(0,0,1,70,100,0, 1,0,0,0);
    add(0,0,1,80,100,0, 2,0,0,0);
    add(0,0,1,90,100,0, 2,0,0,0);
    add(0,0,1,110,100,0, 3,1,0,1);
    add(0,0,1,120,100,0, 3,1,0,0);
    add(0,0,1,130,100,0, 3,1,0,0);
    add(0,0,1,140,100,0, 3,1,0,0);
    add(0,0,1,150,100,0, 4,1,1,0);
    a_end = vt.size();
    // B: falling; prev==thr (100 -> 90) must not fire, 120,110,100 fires on 100.
    add(0,1,0,0,100,1, 1,0,0,0);
    add(0,0,1,130,100,1, 1,0,0,0);
    add(0,0,1,130,100,1, 1,0,0,0);
    add(0,0,1,130,100,1, 1,0,0,0);
    add(0,0,1,100,100,1, 2,0,0,0);
    add(0,0,1,90,100,1, 2,0,0,0);
    add(0,0,1,120,100,1, 2,0,0,0);
    add(0,0,1,110,100,1, 2,0,0,0);
    add(0,0,1,100,100,1, 3,1,0,1);
    add(0,0,1,5,100,1, 3,1,0,0);
    add(0,0,1,6,100,1, 3,1,0,0);
    add(0,0,1,7,100,1, 3,1,0,0);
    add(0,0,1,8,100,1, 4,1,1,0);
    add(1,0,0,0,100,0, 0,0,0,0);
    // C: rising; crossing inside FILL ignored, prev==thr ignored, cur==thr fires.
    add(0,1,0,0,100,0, 1,0,0,0);
    add(0,0,1,50,100,0, 1,0,0,0);
    add(0,0,1,120,100,0, 1,0,0,0);
    add(0,0,1,50,100,0, 1,0,0,0);
    add(0,0,1,100,100,0, 2,0,0,0);
    add(0,0,1,120,100,0, 2,0,0,0);
    add(0,0,0,10,100,0, 2,0,0,0);
    add(0,0,1,90,100,0, 2,0,0,0);
    add(0,0,1,100,100,0, 3,1,0,1);
    add(0,0,1,1,100,0, 3,1,0,0);
    add(0,0,1,2,100,0, 3,1,0,0);
    add(0,0,1,3,100,0, 3,1,0,0);
    add(0,0,1,4,100,0, 4,1,1,0);
    add(1,0,0,0,100,0, 0,0,0,0);
    // D: reset in the middle of POST.
    add(0,1,0,0,100,0, 1,0,0,0);
    add(0,0,1,10,100,0, 1,0,0,0);
    add(0,0,1,20,100,0, 1,0,0,0);
    add(0,0,1,30,100,0, 1,0,0,0);
    add(0,0,1,40,100,0, 2,0,0,0);
    add(0,0,1,200,100,0, 3,1,0,1);
    add(0,0,1,210,100,0, 3,1,0,0);
    add(0,0,1,220,100,0, 3,1,0,0);
    add(1,0,0,0,100,0, 0,0,0,0);
    b_end = vt.size();
    // E: fresh capture after the mid-POST reset.
    add(0,1,0,0,100,0, 1,0,0,0);
    add(0,0,1,11,100,0, 1,0,0,0);
    add(0,0,1,22,100,0, 1,0,0,0);
    add(0,0,1,33,100,0, 1,0,0,0);
    add(0,0,1,44,100,0, 2,0,0,0);
    add(0,0,1,55,100,0, 2,0,0,0);
    add(0,0,1,150,100,0, 3,1,0,1);
    add(0,0,1,160,100,0, 3,1,0,0);
    add(0,0,1,170,100,0, 3,1,0,0);
    add(0,0,1,180,100,0, 3,1,0,0);
    add(0,0,1,190,100,0, 4,1,1,0);
    e_end = vt.size();
    // Re-armed window: no start needed, already in FILL.
    add(0,0,1,10,100,0, 1,0,0,0);
    add(0,0,1,20,100,0, 1,0,0,0);
    add(0,0,1,30,100,0, 1,0,0,0);
    add(0,0,1,40,100,0, 2,0,0,0);
    add(0,0,1,100,100,0, 3,1,0,1);
    add(0,0,1,1,100,0, 3,1,0,0);
    add(0,0,1,2,100,0, 3,1,0,0);
    add(0,0,1,3,100,0, 3,1,0,0);
    add(0,0,1,4,100,0, 4,1,1,0);
    r_end = vt.size();

    run_rows(0, a_end);
    // start in DONE is ignored
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_start_ignored", 32'(current_state), 4);
    chk("a_trigtm_kept", trigtm, exp_tm);
    readout("a", exp_a, 1);

    run_rows(a_end, b_end);
    run_rows(b_end, e_end);
    old_tm = exp_tm;
    readout("e", exp_e, 0);

`ifdef TSC_AUTO_REARM_EN
    run_rows(e_end, r_end);
    total++;
    if (trigtm == old_tm) begin
      bad++;
      $display("FAIL rearm_new_trigtm act=%0d exp=not %0d", trigtm, old_tm);
    end
`else
    if (r_end < e_end) $display("table order unexpected");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
